exec_stage: RTL

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 31 +++
 rtl/exec_wait_cnt.sv | 26 ++
 rtl/exec_stage.sv | 89 ++++++++
 3 files changed

// File: rtl/exec_pkg.sv
// Shared opcode constants, FSM state encoding and overflow helper for the execute stage.
package exec_pkg;

    localparam int OP_W  = 3;
    localparam int CNT_W = 8;

    localparam logic [OP_W-1:0] OP_NOP = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL = 3'd3;
    localparam logic [OP_W-1:0] OP_AND = 3'd4;
    localparam logic [OP_W-1:0] OP_OR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_WAIT = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    // Signed overflow from sign bits only: operands agree (add) or differ (sub) and result flips.
    function automatic logic ovf_detect(input logic [OP_W-1:0] op, input logic a_s,
                                        input logic b_s, input logic r_s);
        case (op)
            OP_ADD:  return (a_s == b_s) && (r_s != a_s);
            OP_SUB:  return (a_s != b_s) && (r_s != a_s);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exec_wait_cnt.sv
// Multiply wait counter: loads a start value, counts down to zero and holds there.
module exec_wait_cnt
    import exec_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/exec_stage.sv
// Execute stage: holds one operation on an external ALU, waits for its result, hands it to writeback.
// Optional EXEC_OVF_FLAG_EN adds an ov_flag output for signed add/sub overflow.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MUL_LATENCY = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [OP_W-1:0]   ULAops,
    output logic [DATA_W-1:0] ULAa,
    output logic [DATA_W-1:0] ULAb,
    input  logic [DATA_W-1:0] ULAout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef EXEC_OVF_FLAG_EN
    ,
    output logic              ov_flag
`endif
);

    state_t state;
    logic   accept, capture, handshake, cnt_zero;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_ready && in_valid;
    assign capture   = (state == ST_EXEC) || ((state == ST_MUL_WAIT) && cnt_zero);
    assign handshake = (state == ST_HOLD) && out_ready;

    exec_wait_cnt u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (accept && (in_op == OP_MUL)),
        .load_val (CNT_W'(MUL_LATENCY - 1)),
        .dec      (state == ST_MUL_WAIT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ULAops    <= OP_NOP;
            ULAa      <= '0;
            ULAb      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    ULAops <= in_op;
                    ULAa   <= in_a;
                    ULAb   <= in_b;
                    state  <= (in_op == OP_MUL) ? ST_MUL_WAIT : ST_EXEC;
                end
                ST_EXEC, ST_MUL_WAIT: if (capture) begin
                    out_data  <= ULAout;
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                end
                // Dropping the opcode lets the ALU multiplier idle between operations.
                ST_HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    ULAops    <= OP_NOP;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef EXEC_OVF_FLAG_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ov_flag <= 1'b0;
        else if (capture)
            ov_flag <= ovf_detect(ULAops, ULAa[DATA_W-1], ULAb[DATA_W-1], ULAout[DATA_W-1]);
        else if (handshake)
            ov_flag <= 1'b0;
    end
`endif

endmodule
